muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer that takes the MUL/DIV work off the single-cycle ALU path. It accepts one operation at a time from the execute stage and runs a radix-2 shift-add multiply or restoring divide over N cycles. It returns a 2N-bit result as lo/hi with an overflow flag, and holds `busy` so the pipeline control can stall dependent instructions.

## Interface
Parameters:
- N, 32, operand and result-half width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU; sampled with start
- s  in  N  multiplicand / dividend; sampled with start
- t  in  N  multiplier / divisor; sampled with start
- kill  in  1  pipeline flush; aborts the operation in flight
- busy  out  1  operation in flight (CALC or FIX)
- done  out  1  one-cycle pulse; lo/hi/overflow are updated on the same edge
- lo  out  N  MUL: product[N-1:0]; DIV: quotient
- hi  out  N  MUL: product[2N-1:N]; DIV: remainder
- overflow  out  1  see Operation; valid from done onward

## Operation
- States: IDLE, CALC, FIX.
- IDLE, with start=1 and kill=0:
  - latch op
  - for signed ops, latch |s| and |t|; for unsigned ops, latch s and t unchanged
  - record result sign and remainder sign
  - clear the 2N accumulator and iteration counter, then go to CALC
- DIV/DIVU with t==0 skips CALC and goes directly to FIX with the divide-by-zero flag set.
- CALC does one iteration per cycle, N iterations, with a counter from 0 to N-1:
  - MUL: if the multiplier LSB is set, add the multiplicand into the upper half; then shift the accumulator right by 1.
  - DIV: shift {rem, quo} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quo LSB.
  - After the Nth iteration go to FIX.
- FIX, in one cycle:
  - apply sign corrections: signed MUL negates the 2N product if the sign of s XOR the sign of t is 1; signed DIV negates the quotient under the same rule and negates the remainder if s is negative
  - write lo and hi, compute overflow, pulse done, go to IDLE
- Overflow rules:
  - MUL: overflow = hi != {N{lo[N-1]}}
  - MULU: overflow = hi != 0
  - DIV/DIVU with t==0: lo=0, hi=0, overflow=1
  - DIV with s=0x80000000 (most-negative N-bit value) and t=all-ones: lo=s, hi=0, overflow=1
  - all other divides: overflow=0
- Rounding: the quotient truncates toward zero; the remainder takes the dividend's sign; |rem| < |t|.
- start while busy=1 is ignored and not queued. The requester holds start until it sees done.
- kill=1 in CALC or FIX: go to IDLE at the next edge; no done pulse; lo/hi/overflow unchanged.
- kill=1 in IDLE blocks start in that cycle.
- reset overrides everything: state IDLE, busy=0, done=0, lo=0, hi=0, overflow=0, accumulator and counter cleared.

## Timing
- E0 = the rising edge at which start is accepted.
- busy is registered: 1 after E0, 0 after the FIX edge. done is 1 only in the cycle following the FIX edge.
- Normal op: CALC occupies E1..EN, FIX is E(N+1). done, lo, hi and overflow change at E(N+1). Latency is N+1 edges (33 for N=32).
- Divide by zero: FIX at E1; done high after E1. Latency is 1.
- busy=0 and state is IDLE during the done cycle. A start presented in the done cycle is accepted at E(N+2), giving back-to-back throughput of one operation per N+2 cycles.
- lo, hi and overflow hold their value until the next FIX edge or reset.
- kill at edge Ek (1≤k≤N+1) takes priority over FIX: state is IDLE after Ek and done never rises.
- reset asserted at any edge gives reset values after that edge. This includes the FIX edge, where reset wins over done.

## Test plan
- MUL s=7, t=0xFFFFFFFD (−3) → done after E33; lo=0xFFFFFFEB, hi=0xFFFFFFFF, overflow=0; busy high E1–E32.
- MULU s=0xFFFFFFFF, t=2 → lo=0xFFFFFFFE, hi=0x00000001, overflow=1. MUL s=0x10000, t=0x10000 → lo=0, hi=1, overflow=1.
- DIV s=0xFFFFFFF9 (−7), t=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, overflow=0. DIVU s=100, t=7 → lo=14, hi=2.
- DIVU s=100, t=0 → done after E1, lo=0, hi=0, overflow=1. DIV s=0x80000000, t=0xFFFFFFFF → lo=0x80000000, hi=0, overflow=1.
- Hold start high with new operands through a running MULU → they are ignored until the done cycle, then accepted; the second done comes exactly 34 cycles after the first.
- kill at E10 of a MUL → no done pulse, lo/hi keep their previous values, the next start is accepted. reset at E20 → all outputs 0 and busy=0 after that edge.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide sequencer.
// Holds busy for N+1 cycles per operation and returns a 2N-bit result as lo/hi plus overflow.
module muldiv_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] s_i,
    input  logic [N-1:0] t_i,
    input  logic         kill_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o,
    output logic         overflow_o
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             div_ovf_q, div_ovf_d;
    logic [N-1:0]     lo_q, lo_d;
    logic [N-1:0]     hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             sgn_in;
    logic [N-1:0]     abs_s, abs_t;
    logic [N:0]       mul_sum;
    logic [N:0]       rem_sh;
    logic [N+1:0]     diff;
    logic [2*N-1:0]   prod_fix;
    logic [N-1:0]     quo_fix, rem_fix;

    assign sgn_in  = ~op_i[0];
    assign abs_s   = (sgn_in && s_i[N-1]) ? -s_i : s_i;
    assign abs_t   = (sgn_in && t_i[N-1]) ? -t_i : t_i;
    assign mul_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, (b_q[0] ? a_q : {N{1'b0}})};
    // Next dividend bit (MSB of a_q) shifts into the partial remainder.
    assign rem_sh  = {acc_q[2*N-1:N], a_q[N-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, b_q};
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        div_ovf_d = div_ovf_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !kill_i) begin
                    op_d      = op_i;
                    a_d       = abs_s;
                    b_d       = abs_t;
                    neg_res_d = sgn_in & (s_i[N-1] ^ t_i[N-1]);
                    neg_rem_d = sgn_in & s_i[N-1];
                    acc_d     = '0;
                    cnt_d     = '0;
                    dz_d      = op_i[1] && (t_i == '0);
                    div_ovf_d = (op_i == 2'b10) && (s_i == {1'b1, {(N-1){1'b0}}})
                                && (t_i == '1);
                    state_d   = (op_i[1] && (t_i == '0)) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[1]) begin
                        acc_d = {(diff[N+1] ? rem_sh[N-1:0] : diff[N-1:0]),
                                 acc_q[N-2:0], ~diff[N+1]};
                        a_d   = a_q << 1;
                    end else begin
                        acc_d = {mul_sum, acc_q[N-1:1]};
                        b_d   = b_q >> 1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!kill_i) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        lo_d  = dz_q ? '0 : quo_fix;
                        hi_d  = dz_q ? '0 : rem_fix;
                        ovf_d = dz_q | div_ovf_q;
                    end else begin
                        lo_d  = prod_fix[N-1:0];
                        hi_d  = prod_fix[2*N-1:N];
                        ovf_d = op_q[0] ? (prod_fix[2*N-1:N] != '0)
                                        : (prod_fix[2*N-1:N] != {N{prod_fix[N-1]}});
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            div_ovf_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            div_ovf_q <= div_ovf_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign lo_o       = lo_q;
    assign hi_o       = hi_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results, a monitor checks each done.
module tb_muldiv_seq;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic         kill;
    logic         busy;
    logic         done;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    muldiv_seq #(.N(N)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .op_i       (op),
        .s_i        (s),
        .t_i        (t),
        .kill_i     (kill),
        .busy_o     (busy),
        .done_o     (done),
        .lo_o       (lo),
        .hi_o       (hi),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] elo, input logic [N-1:0] ehi, input logic eovf);
        exp_t e;
        e.lo  = elo;
        e.hi  = ehi;
        e.ovf = eovf;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 with no pending operation");
            end else begin
                mon_e = sb.pop_front();
                chk("lo", {32'h0, lo}, {32'h0, mon_e.lo});
                chk("hi", {32'h0, hi}, {32'h0, mon_e.hi});
                chk("overflow", {63'h0, overflow}, {63'h0, mon_e.ovf});
                chk("busy_in_done", {63'h0, busy}, 64'h0);
            end
        end
    end

    // Issue one op, hold start until done, check latency (and busy if asked).
    task automatic do_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] elo, input logic [N-1:0] ehi, input logic eovf,
                         input bit check_busy);
        int cyc;
        int lat_exp;
        bit got;
        lat_exp = (o[1] && b == '0) ? 1 : N + 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        s     = a;
        t     = b;
        push(elo, ehi, eovf);
        cyc = 0;
        got = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
                break;
            end
            if (check_busy && cyc >= 2) chk("busy_during_op", {63'h0, busy}, 64'h1);
        end
        start = 1'b0;
        chk("done_seen", {63'h0, got}, 64'h1);
        if (got) chk("latency", 64'(cyc - 2), 64'(lat_exp));
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        s     = '0;
        t     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_ovf", {63'h0, overflow}, 64'h0);
        reset = 1'b0;

        do_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b1);
        do_op(2'b01, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
        do_op(2'b00, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 1'b1, 1'b0);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        do_op(2'b11, 32'd100, 32'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0);
        do_op(2'b10, 32'h80000000, 32'd2, 32'hC0000000, 32'h0, 1'b0, 1'b0);

        // start held high with changed operands while busy: only accepted in the done cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b01;
        s     = 32'hFFFFFFFF;
        t     = 32'd2;
        push(32'hFFFFFFFE, 32'h1, 1'b1);
        @(posedge clk);
        #1;
        s = 32'd3;
        t = 32'd5;
        push(32'd15, 32'h0, 1'b0);
        cyc = 0;
        d1  = -1;
        d2  = -1;
        while (cyc < 300 && d2 < 0) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        chk("hold_second_done", {63'h0, (d2 >= 0)}, 64'h1);
        if (d2 >= 0) chk("b2b_gap", 64'(d2 - d1), 64'd34);

        // kill at E10 of a MUL: no done, outputs keep 15/0/0
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        s     = 32'd7;
        t     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", {63'h0, busy}, 64'h0);
        chk("kill_done", {63'h0, done}, 64'h0);
        chk("kill_lo", {32'h0, lo}, 64'd15);
        chk("kill_hi", {32'h0, hi}, 64'h0);
        chk("kill_ovf", {63'h0, overflow}, 64'h0);
        repeat (40) @(posedge clk);

        // kill in IDLE blocks start
        #1;
        start = 1'b1;
        kill  = 1'b1;
        op    = 2'b11;
        s     = 32'd100;
        t     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_idle_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(posedge clk);

        do_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

        // reset at E20 of a MUL
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        s     = 32'd7;
        t     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst20_busy", {63'h0, busy}, 64'h0);
        chk("rst20_done", {63'h0, done}, 64'h0);
        chk("rst20_lo", {32'h0, lo}, 64'h0);
        chk("rst20_hi", {32'h0, hi}, 64'h0);
        chk("rst20_ovf", {63'h0, overflow}, 64'h0);
        reset = 1'b0;
        repeat (40) @(posedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
